systolic_sequencer: RTL

- Controller between the operand SIPO and the `systolic_array` instance.
- Sequences one matrix-multiply job: accepts operand bytes, forwards them to the array through a one-entry holding register, and collects `array_height_p*array_width_p` results into an internal buffer.
- Then steps the buffered results out to the seven-segment display path one per `step_i` tick.
- Replaces ad-hoc edge-detect/pulse-stretch glue and the display-flag logic in the top level.

---
 rtl/systolic_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_sequencer.sv
// Job sequencer for the systolic array: streams operand bytes through a one-entry holding
// register, buffers the result matrix, then steps the results out to the display path.
module systolic_sequencer #(
  parameter int unsigned width_p        = 8,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned depth_p        = 2,
  parameter int unsigned timeout_p      = 1024
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  input  logic                                             abort_i,
  input  logic                                             in_valid_i,
  input  logic [width_p-1:0]                               in_data_i,
  output logic                                             in_ready_o,
  output logic                                             sa_valid_o,
  output logic [width_p-1:0]                               sa_data_o,
  input  logic                                             sa_ready_i,
  output logic                                             sa_flush_o,
  input  logic                                             sa_valid_i,
  input  logic [width_p-1:0]                               sa_data_i,
  output logic                                             sa_yumi_o,
  input  logic                                             step_i,
  output logic                                             disp_valid_o,
  output logic [width_p-1:0]                               disp_data_o,
  output logic [$clog2(array_height_p*array_width_p)-1:0] disp_idx_o,
  output logic [2:0]                                       state_o,
  output logic                                             done_o,
  output logic                                             error_o
);

  localparam int unsigned NOp  = array_height_p * depth_p + depth_p * array_width_p;
  localparam int unsigned NRes = array_height_p * array_width_p;
  localparam int unsigned IdxW = $clog2(NRes);
  localparam int unsigned CntW = $clog2(NOp + 1);
  localparam int unsigned ResW = $clog2(NRes + 1);
  localparam int unsigned ToW  = $clog2(timeout_p + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StCompute = 3'd2,
    StShow    = 3'd3,
    StError   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        acc_cnt_q, acc_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [ResW-1:0]        res_cnt_q, res_cnt_d;
  logic [ToW-1:0]         to_cnt_q, to_cnt_d;
  logic [IdxW-1:0]        disp_idx_q, disp_idx_d;
  logic                   hold_v_q, hold_v_d;
  logic [width_p-1:0]     hold_d_q, hold_d_d;
  logic [NRes-1:0]        buf_v_q, buf_v_d;
  logic [width_p-1:0]     buf_q [NRes];
  logic                   flush_q, flush_d;
  logic                   wr_en;
  logic                   accept, xfer;

  assign in_ready_o = ((state_q == StIdle) || (state_q == StLoad)) &&
                      (acc_cnt_q < CntW'(NOp)) && (!hold_v_q || sa_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign xfer       = hold_v_q & sa_ready_i;

  assign sa_valid_o   = hold_v_q;
  assign sa_data_o    = hold_d_q;
  assign sa_flush_o   = flush_q;
  assign disp_valid_o = (state_q == StShow) & buf_v_q[disp_idx_q];
  assign disp_data_o  = (state_q == StShow) ? buf_q[disp_idx_q] : '0;
  assign disp_idx_o   = disp_idx_q;
  assign state_o      = state_q;
  assign error_o      = (state_q == StError);

  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    fwd_cnt_d  = fwd_cnt_q;
    res_cnt_d  = res_cnt_q;
    to_cnt_d   = to_cnt_q;
    disp_idx_d = disp_idx_q;
    hold_d_d   = hold_d_q;
    buf_v_d    = buf_v_q;
    flush_d    = 1'b0;
    done_o     = 1'b0;
    sa_yumi_o  = 1'b0;
    wr_en      = 1'b0;

    // Accept and forward may coincide, giving one byte per cycle.
    hold_v_d = accept | (hold_v_q & ~xfer);
    if (accept) begin
      hold_d_d  = in_data_i;
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    if (xfer) fwd_cnt_d = fwd_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StLoad;
      end
      StLoad: begin
        if (xfer && (fwd_cnt_q == CntW'(NOp - 1))) begin
          state_d  = StCompute;
          to_cnt_d = '0;
        end
      end
      StCompute: begin
        sa_yumi_o = sa_valid_i;
        if (sa_valid_i) begin
          wr_en                         = 1'b1;
          buf_v_d[res_cnt_q[IdxW-1:0]] = 1'b1;
          res_cnt_d                     = res_cnt_q + 1'b1;
          to_cnt_d                      = '0;
          if (res_cnt_q == ResW'(NRes - 1)) begin
            state_d    = StShow;
            disp_idx_d = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == ToW'(timeout_p)) begin
            state_d = StError;
            flush_d = 1'b1;
          end
        end
      end
      StShow: begin
        if (step_i) begin
          if (disp_idx_q == IdxW'(NRes - 1)) begin
            state_d    = StIdle;
            done_o     = 1'b1;
            acc_cnt_d  = '0;
            fwd_cnt_d  = '0;
            res_cnt_d  = '0;
            to_cnt_d   = '0;
            disp_idx_d = '0;
            buf_v_d    = '0;
          end else begin
            disp_idx_d = disp_idx_q + 1'b1;
          end
        end
      end
      StError: ;
      default: state_d = StIdle;
    endcase

    // Abort overrides any accept, result or step in the same cycle.
    if (abort_i) begin
      state_d    = StIdle;
      acc_cnt_d  = '0;
      fwd_cnt_d  = '0;
      res_cnt_d  = '0;
      to_cnt_d   = '0;
      disp_idx_d = '0;
      buf_v_d    = '0;
      hold_v_d   = 1'b0;
      flush_d    = 1'b1;
      done_o     = 1'b0;
      sa_yumi_o  = 1'b0;
      wr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      acc_cnt_q  <= '0;
      fwd_cnt_q  <= '0;
      res_cnt_q  <= '0;
      to_cnt_q   <= '0;
      disp_idx_q <= '0;
      hold_v_q   <= 1'b0;
      hold_d_q   <= '0;
      buf_v_q    <= '0;
      flush_q    <= 1'b0;
      buf_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
      res_cnt_q  <= res_cnt_d;
      to_cnt_q   <= to_cnt_d;
      disp_idx_q <= disp_idx_d;
      hold_v_q   <= hold_v_d;
      hold_d_q   <= hold_d_d;
      buf_v_q    <= buf_v_d;
      flush_q    <= flush_d;
      if (wr_en) buf_q[res_cnt_q[IdxW-1:0]] <= sa_data_i;
    end
  end

endmodule
